// File: rtl/trap_ctrl.sv
// trap_ctrl: sequences the CSR writes and PC redirect for ecall/ebreak/interrupt traps and mret.
// Traps write mepc, mstatus, mcause then redirect to mtvec; mret writes mstatus then redirects to mepc.
module trap_ctrl #(
    parameter logic [31:0] IRQ_CAUSE    = 32'h8000_0007,
    parameter logic [31:0] ECALL_CAUSE  = 32'd11,
    parameter logic [31:0] EBREAK_CAUSE = 32'd3
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        ecall_i,
    input  logic        ebreak_i,
    input  logic        mret_i,
    input  logic [31:0] inst_addr_i,
    input  logic        jump_flag_i,
    input  logic [31:0] jump_addr_i,
    input  logic        irq_i,
    input  logic        busy_i,
    input  logic        global_int_en_i,
    input  logic [31:0] csr_mtvec_i,
    input  logic [31:0] csr_mepc_i,
    input  logic [31:0] csr_mstatus_i,
    output logic        csr_we_o,
    output logic [31:0] csr_waddr_o,
    output logic [31:0] csr_wdata_o,
    output logic        hold_o,
    output logic        int_assert_o,
    output logic [31:0] int_addr_o
);
    typedef enum logic [2:0] {IDLE, W_MEPC, W_MSTATUS, W_MCAUSE, W_MRET, REDIRECT} state_t;

    state_t      state, state_n;
    logic [31:0] mepc_q, cause_q, target_q;
    logic        irq_ok, sync_trap;

    assign irq_ok    = irq_i && global_int_en_i && !busy_i;
    assign sync_trap = ecall_i || ebreak_i;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state    <= IDLE;
            mepc_q   <= '0;
            cause_q  <= '0;
            target_q <= '0;
        end else begin
            state <= state_n;
            if (state == IDLE && sync_trap) begin
                mepc_q  <= inst_addr_i;
                cause_q <= ecall_i ? ECALL_CAUSE : EBREAK_CAUSE;
            end else if (state == IDLE && !mret_i && irq_ok) begin
                // an interrupt must resume at the jump target if EX was redirecting
                mepc_q  <= jump_flag_i ? jump_addr_i : inst_addr_i;
                cause_q <= IRQ_CAUSE;
            end
            if (state == W_MCAUSE) target_q <= csr_mtvec_i;
            if (state == W_MRET) target_q <= csr_mepc_i;
        end
    end

    always_comb begin
        state_n      = state;
        csr_we_o     = 1'b0;
        csr_waddr_o  = '0;
        csr_wdata_o  = '0;
        int_assert_o = 1'b0;
        int_addr_o   = '0;
        case (state)
            IDLE:      state_n = (sync_trap || (!mret_i && irq_ok)) ? W_MEPC : mret_i ? W_MRET : IDLE;
            W_MEPC: begin
                csr_we_o    = 1'b1;
                csr_waddr_o = 32'h341;
                csr_wdata_o = mepc_q;
                state_n     = W_MSTATUS;
            end
            W_MSTATUS: begin
                csr_we_o    = 1'b1;
                csr_waddr_o = 32'h300;
                csr_wdata_o = {csr_mstatus_i[31:8], csr_mstatus_i[3], csr_mstatus_i[6:4], 1'b0, csr_mstatus_i[2:0]};
                state_n     = W_MCAUSE;
            end
            W_MCAUSE: begin
                csr_we_o    = 1'b1;
                csr_waddr_o = 32'h342;
                csr_wdata_o = cause_q;
                state_n     = REDIRECT;
            end
            W_MRET: begin
                csr_we_o    = 1'b1;
                csr_waddr_o = 32'h300;
                csr_wdata_o = {csr_mstatus_i[31:8], 1'b1, csr_mstatus_i[6:4], csr_mstatus_i[7], csr_mstatus_i[2:0]};
                state_n     = REDIRECT;
            end
            REDIRECT: begin
                int_assert_o = 1'b1;
                int_addr_o   = target_q;
                state_n      = IDLE;
            end
            default:   state_n = IDLE;
        endcase
    end

    // reset forces hold low even though IDLE would otherwise react to live inputs
    assign hold_o = !rst_i && (state != IDLE || sync_trap || mret_i || irq_ok);
endmodule

// File: tb/tb_trap_ctrl.sv
// tb_trap_ctrl: randomized scoreboard bench for trap_ctrl against a cycle-stamped transaction model.
module tb_trap_ctrl;
    logic        clk = 0, rst = 1;
    logic        ecall = 0, ebreak = 0, mret = 0, irq = 0, busy = 0, mie = 0, jf = 0;
    logic [31:0] pc = 0, ja = 0, mtvec = 0, mepc = 0, mstatus = 0;
    logic        csr_we, hold, int_assert;
    logic [31:0] csr_waddr, csr_wdata, int_addr;

    trap_ctrl dut (
        .clk_i(clk), .rst_i(rst), .ecall_i(ecall), .ebreak_i(ebreak), .mret_i(mret),
        .inst_addr_i(pc), .jump_flag_i(jf), .jump_addr_i(ja), .irq_i(irq), .busy_i(busy),
        .global_int_en_i(mie), .csr_mtvec_i(mtvec), .csr_mepc_i(mepc), .csr_mstatus_i(mstatus),
        .csr_we_o(csr_we), .csr_waddr_o(csr_waddr), .csr_wdata_o(csr_wdata),
        .hold_o(hold), .int_assert_o(int_assert), .int_addr_o(int_addr)
    );

    always #5 clk = ~clk;

    typedef struct {int cyc; bit redir; logic [31:0] addr; logic [31:0] data;} exp_t;
    typedef struct {logic [31:0] mtvec; logic [31:0] mepc; logic [31:0] mstatus;} csr_t;

    exp_t q[$];
    csr_t plan[$];
    int   cyc = 0, free_at = 0, n_chk = 0, n_fail = 0;
    bit   exp_hold = 0, mon_en = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got %h expected %h", nm, cyc, act, exp);
        end
    endtask

    function automatic csr_t rnd_csr();
        csr_t c;
        c.mtvec   = $urandom & 32'hffff_fffc;
        c.mepc    = $urandom & 32'hffff_fffc;
        c.mstatus = $urandom;
        return c;
    endfunction

    // trap: MPIE takes old MIE, MIE cleared; mret: MIE takes MPIE, MPIE set
    function automatic logic [31:0] trap_st(input logic [31:0] m);
        return (m & ~32'h88) | (((m >> 3) & 1) << 7);
    endfunction
    function automatic logic [31:0] mret_st(input logic [31:0] m);
        return (m & ~32'h8) | (((m >> 7) & 1) << 3) | 32'h80;
    endfunction

    task automatic step(input bit e, b, m, i, bz, ie, input logic [31:0] p, input bit j, input logic [31:0] jt);
        csr_t c;
        bit   idle, irq_ok;
        logic [31:0] ep, cause;
        @(posedge clk);
        #1;
        c = plan.size() > 0 ? plan.pop_front() : rnd_csr();
        {ecall, ebreak, mret, irq, busy, mie, pc, jf, ja} = {e, b, m, i, bz, ie, p, j, jt};
        {mtvec, mepc, mstatus} = {c.mtvec, c.mepc, c.mstatus};
        idle     = cyc >= free_at;
        irq_ok   = i && ie && !bz;
        exp_hold = !idle || e || b || m || irq_ok;
        if (idle && (e || b || (!m && irq_ok))) begin
            ep    = (e || b) ? p : (j ? jt : p);
            cause = e ? 32'd11 : b ? 32'd3 : 32'h8000_0007;
            repeat (4) plan.push_back(rnd_csr());
            q.push_back(exp_t'{cyc + 1, 1'b0, 32'h341, ep});
            q.push_back(exp_t'{cyc + 2, 1'b0, 32'h300, trap_st(plan[1].mstatus)});
            q.push_back(exp_t'{cyc + 3, 1'b0, 32'h342, cause});
            q.push_back(exp_t'{cyc + 4, 1'b1, 32'h0, plan[2].mtvec});
            free_at = cyc + 5;
        end else if (idle && m) begin
            repeat (2) plan.push_back(rnd_csr());
            q.push_back(exp_t'{cyc + 1, 1'b0, 32'h300, mret_st(plan[0].mstatus)});
            q.push_back(exp_t'{cyc + 2, 1'b1, 32'h0, plan[0].mepc});
            free_at = cyc + 3;
        end
    endtask

    task automatic idle_steps(input int n);
        repeat (n) step(0, 0, 0, 0, 0, 0, 32'h0, 0, 32'h0);
    endtask

    // monitor: compare whatever the DUT presents this cycle against the scoreboard head
    always @(negedge clk) begin
        exp_t x;
        if (mon_en) begin
            chk("hold", hold, exp_hold);
            if (q.size() > 0 && q[0].cyc == cyc) begin
                x = q.pop_front();
                chk(x.redir ? "redir_strobe" : "csr_we", x.redir ? int_assert : csr_we, 1'b1);
                if (x.redir) begin
                    chk("int_addr", int_addr, x.data);
                    chk("csr_we_in_redir", csr_we, 1'b0);
                end else begin
                    chk("csr_waddr", csr_waddr, x.addr);
                    chk("csr_wdata", csr_wdata, x.data);
                    chk("int_assert_in_write", int_assert, 1'b0);
                end
            end else begin
                chk("quiet_we", csr_we, 1'b0);
                chk("quiet_int", int_assert, 1'b0);
                chk("quiet_waddr", csr_waddr, 32'h0);
                chk("quiet_wdata", csr_wdata, 32'h0);
                chk("quiet_int_addr", int_addr, 32'h0);
            end
        end
    end

    initial begin
        ecall = 1; irq = 1; mie = 1;
        #12;
        chk("rst_hold", hold, 1'b0);
        chk("rst_we", csr_we, 1'b0);
        chk("rst_int", int_assert, 1'b0);
        chk("rst_waddr", csr_waddr, 32'h0);
        @(posedge clk);
        #1;
        {rst, ecall, irq, mie} = 4'b0;
        free_at = 0;
        mon_en  = 1;
        idle_steps(2);
        step(1, 0, 0, 0, 0, 0, 32'h100, 0, 32'h0);
        idle_steps(5);
        step(0, 0, 0, 1, 0, 1, 32'h1f0, 1, 32'h200);
        idle_steps(5);
        repeat (3) step(0, 0, 0, 1, 1, 1, 32'h300, 0, 32'h0);
        step(0, 0, 0, 1, 0, 1, 32'h304, 0, 32'h0);
        idle_steps(5);
        step(0, 0, 1, 0, 0, 0, 32'h400, 0, 32'h0);
        idle_steps(3);
        repeat (6) step(1, 0, 0, 1, 0, 1, 32'h500, 0, 32'h0);
        idle_steps(6);
        step(0, 1, 1, 1, 0, 1, 32'h600, 1, 32'h640);
        idle_steps(5);
        repeat (3000)
            step($urandom_range(0, 11) == 0, $urandom_range(0, 11) == 0, $urandom_range(0, 11) == 0,
                 $urandom_range(0, 3) == 0, $urandom_range(0, 2) == 0, $urandom_range(0, 3) != 0,
                 $urandom & 32'hffff_fffc, $urandom_range(0, 1) == 1, $urandom & 32'hffff_fffc);
        idle_steps(8);
        chk("scoreboard_drained", q.size(), 0);
        mon_en = 0;
        step(1, 0, 0, 0, 0, 0, 32'h700, 0, 32'h0);
        idle_steps(2);
        chk("mid_we_before_rst", csr_we, 1'b1);
        chk("mid_waddr_before_rst", csr_waddr, 32'h300);
        #2 rst = 1;
        #1;
        chk("mid_rst_we", csr_we, 1'b0);
        chk("mid_rst_hold", hold, 1'b0);
        chk("mid_rst_waddr", csr_waddr, 32'h0);
        chk("mid_rst_wdata", csr_wdata, 32'h0);
        chk("mid_rst_int", int_assert, 1'b0);
        @(posedge clk);
        #1 rst = 0;
        q.delete();
        plan.delete();
        free_at = 0;
        repeat (6) begin
            @(negedge clk);
            chk("post_rst_we", csr_we, 1'b0);
            chk("post_rst_int", int_assert, 1'b0);
            chk("post_rst_hold", hold, 1'b0);
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/trap_ctrl.md
TRAP_CTRL -- requirements
Module: trap_ctrl

Interface
REQ-001 SHALL have parameter IRQ_CAUSE, default 32'h8000_0007, the mcause value written for an external interrupt.
REQ-002 SHALL have parameter ECALL_CAUSE, default 32'd11; EBREAK_CAUSE, default 32'd3.
REQ-003 SHALL have one clock; reset is asynchronous and active-high.
REQ-004 SHALL have port clk_i  in  1  core clock.
REQ-005 SHALL have port rst_i  in  1  async active-high reset.
REQ-006 SHALL have port ecall_i / ebreak_i / mret_i  in  1 each  decoded instruction in EX.
REQ-007 SHALL have port inst_addr_i  in  32  PC of the instruction in EX.
REQ-008 SHALL have port jump_flag_i  in  1  EX is taking a jump; jump_addr_i  in  32  its target.
REQ-009 SHALL have port irq_i  in  1  level interrupt request.
REQ-010 SHALL have port busy_i  in  1  multi-cycle op (divider) in progress.
REQ-011 SHALL have port global_int_en_i  in  1  mstatus.MIE from the CSR file.
REQ-012 SHALL have ports csr_mtvec_i, csr_mepc_i, csr_mstatus_i  in  32 each  current CSR values.
REQ-013 SHALL have port csr_we_o  out  1; csr_waddr_o  out  32; csr_wdata_o  out  32  CSR write port.
REQ-014 SHALL have port hold_o  out  1  pipeline stall request.
REQ-015 SHALL have port int_assert_o  out  1; int_addr_o  out  32  redirect PC strobe and target.

Function
REQ-016 SHALL implement FSM states IDLE, W_MEPC, W_MSTATUS, W_MCAUSE, W_MRET, REDIRECT.
REQ-017 In IDLE, event priority SHALL be ecall > ebreak > mret > interrupt; an interrupt is taken only when irq_i && global_int_en_i && !busy_i.
REQ-018 On a taken ecall/ebreak in IDLE: latch mepc_q=inst_addr_i, cause_q=ECALL_CAUSE/EBREAK_CAUSE, go to W_MEPC.
REQ-019 On a taken interrupt: latch mepc_q = jump_flag_i ? jump_addr_i : inst_addr_i, cause_q=IRQ_CAUSE, go to W_MEPC.
REQ-020 On mret in IDLE: go to W_MRET.
REQ-021 hold_o SHALL be combinationally high in the IDLE cycle an event is taken and in every non-IDLE state, including REDIRECT.
REQ-022 W_MEPC: csr_we_o=1, csr_waddr_o=0x341, csr_wdata_o=mepc_q; next W_MSTATUS.
REQ-023 W_MSTATUS: write 0x300 with csr_mstatus_i, bit7 (MPIE) set to bit3 (MIE) and bit3 cleared; next W_MCAUSE.
REQ-024 W_MCAUSE: write 0x342 with cause_q; next REDIRECT, with the redirect target latched as csr_mtvec_i.
REQ-025 W_MRET: write 0x300 with csr_mstatus_i, bit3 set to bit7 and bit7 set to 1; next REDIRECT, with the target latched as csr_mepc_i.
REQ-026 REDIRECT: int_assert_o=1 and int_addr_o equal to the latched target for exactly one cycle; csr_we_o=0; next IDLE.
REQ-027 Trap latency SHALL be 4 cycles from event to int_assert_o; mret latency SHALL be 2 cycles.
REQ-028 Outside the write states, csr_we_o=0, csr_waddr_o=0 and csr_wdata_o=0; int_assert_o=0 and int_addr_o=0 outside REDIRECT.
REQ-029 Events arriving while not in IDLE SHALL be ignored (not queued).
REQ-030 An irq_i held with busy_i=1 SHALL be deferred and taken on the first IDLE cycle with busy_i=0 and the interrupt still enabled.
REQ-031 Only bits [11:0] of csr_waddr_o carry meaning; upper bits SHALL be 0.

Reset
REQ-032 While rst_i=1, state SHALL be IDLE, mepc_q, cause_q and the latched target SHALL be 0, and all outputs SHALL be 0, independent of clk_i.
REQ-033 Reset asserted mid-sequence SHALL abort the sequence with no further CSR write or redirect after release.

Verification
REQ-034 ecall_i=1, inst_addr_i=0x100, mtvec=0x80 -> next three cycles write 0x341=0x100, 0x300 (MIE cleared), 0x342=11; then int_assert_o=1, int_addr_o=0x80; hold_o high for all 5 cycles.
REQ-035 irq_i=1, MIE=1, jump_flag_i=1, jump_addr_i=0x200 -> mepc written 0x200, mcause written 0x8000_0007.
REQ-036 irq_i=1 with busy_i=1 for 3 cycles, then busy_i=0 -> no csr_we_o during busy; sequence starts the cycle busy_i falls.
REQ-037 mret_i=1, mstatus=0x80, mepc=0x104 -> write 0x300=0x88, then int_assert_o=1, int_addr_o=0x104.
REQ-038 ecall_i and irq_i both high in the same cycle -> cause 11; irq ignored until IDLE.
REQ-039 rst_i pulsed during W_MSTATUS -> outputs 0 immediately; no 0x342 write or redirect after release.
